switch_voq_islip_sched: RTL and testbench

Frame-granular, single-iteration iSLIP matching scheduler for the input-queued VOQ switch. It sits between the RADIX×RADIX virtual output queues and the crossbar. It observes which VOQs hold a frame head and computes a conflict-free input→output matching. It holds each connection until the frame's last beat is transferred on that output.

---
 rtl/switch_voq_islip_sched_pkg.sv | 27 ++
 rtl/switch_voq_islip_sched_rr_arbiter.sv | 35 +++
 rtl/switch_voq_islip_sched.sv | 102 ++++++++++
 tb/tb_switch_voq_islip_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_voq_islip_sched_pkg.sv
// Shared constants and index helpers for the VOQ iSLIP scheduler.
// Index helpers are shared with the crossbar.
package switch_voq_islip_sched_pkg;

  localparam int RADIX_DEF = 4;

  function automatic int ptr_w(input int radix);
    return (radix < 2) ? 1 : $clog2(radix);
  endfunction

  // VOQ indexing: input n, output m
  function automatic int voq_idx(input int n, input int m,
                                 input int radix);
    return n * radix + m;
  endfunction

  // Crossbar indexing: output m, input n
  function automatic int xbar_idx(input int m, input int n,
                                  input int radix);
    return m * radix + n;
  endfunction

  function automatic int wrap_inc(input int v, input int radix);
    return (v + 1 >= radix) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/switch_voq_islip_sched_rr_arbiter.sv
// Combinational round-robin select: first request at or after ptr,
// wrapping; returns one-hot grant and its encoded index.
module switch_rr_arbiter
  import switch_voq_islip_sched_pkg::*;
#(
  parameter int RADIX = RADIX_DEF,
  localparam int PTR_WIDTH = ptr_w(RADIX)
) (
  input  logic [RADIX-1:0]     req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [RADIX-1:0]     gnt,
  output logic [PTR_WIDTH-1:0] idx
);

  logic [RADIX-1:0] lo_mask;
  logic [RADIX-1:0] hi_req;
  logic [RADIX-1:0] pick;
  logic [PTR_WIDTH-1:0] enc [RADIX+1];

  // Prefer requests at or above ptr, else wrap to the lowest one
  always_comb begin
    lo_mask = (RADIX'(1) << ptr) - RADIX'(1);
    hi_req  = req & ~lo_mask;
    pick    = (|hi_req) ? hi_req : req;
    gnt     = pick & (~pick + RADIX'(1));
  end

  assign enc[0] = '0;
  for (genvar i = 0; i < RADIX; i++) begin : g_enc
    assign enc[i+1] = enc[i] |
      (gnt[i] ? PTR_WIDTH'(i) : '0);
  end
  assign idx = enc[RADIX];

endmodule

// File: rtl/switch_voq_islip_sched.sv
// Single-iteration iSLIP matcher with frame-granular hold.
// Connections persist until the output sees its last beat.
module switch_voq_islip_sched
  import switch_voq_islip_sched_pkg::*;
#(
  parameter int RADIX = RADIX_DEF,
  localparam int PTR_WIDTH = ptr_w(RADIX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RADIX*RADIX-1:0] voq_req,
  input  logic [RADIX-1:0]       xfer_last,
  output logic [RADIX*RADIX-1:0] match,
  output logic [RADIX-1:0]       match_valid
);

  logic                 out_busy   [RADIX];
  logic                 in_busy    [RADIX];
  logic [PTR_WIDTH-1:0] out_in     [RADIX];
  logic [PTR_WIDTH-1:0] grant_ptr  [RADIX];
  logic [PTR_WIDTH-1:0] accept_ptr [RADIX];

  logic [RADIX-1:0]     g_req [RADIX];
  logic [RADIX-1:0]     g_gnt [RADIX];
  logic [PTR_WIDTH-1:0] g_idx [RADIX];
  logic [RADIX-1:0]     a_req [RADIX];
  logic [RADIX-1:0]     a_gnt [RADIX];
  logic [PTR_WIDTH-1:0] a_idx [RADIX];
  logic [RADIX-1:0]     t_mat [RADIX];
  logic [RADIX-1:0]     r_mat [RADIX];
  logic [RADIX-1:0]     a_any;
  logic [RADIX-1:0]     out_take;
  logic [RADIX-1:0]     rel_in;

  for (genvar m = 0; m < RADIX; m++) begin : g_xy
    for (genvar n = 0; n < RADIX; n++) begin : g_n
      assign g_req[m][n] = voq_req[voq_idx(n, m, RADIX)] &
                           ~in_busy[n] & ~out_busy[m];
      assign a_req[n][m] = g_gnt[m][n];
      assign t_mat[m][n] = a_gnt[n][m];
      assign r_mat[n][m] = xfer_last[m] & out_busy[m] &
                           (out_in[m] == PTR_WIDTH'(n));
      assign match[xbar_idx(m, n, RADIX)] = out_busy[m] &
                           (out_in[m] == PTR_WIDTH'(n));
    end
  end

  for (genvar m = 0; m < RADIX; m++) begin : g_out
    switch_rr_arbiter #(.RADIX(RADIX)) u_grant (
      .req (g_req[m]),
      .ptr (grant_ptr[m]),
      .gnt (g_gnt[m]),
      .idx (g_idx[m])
    );

    assign out_take[m]    = |t_mat[m];
    assign match_valid[m] = out_busy[m];

    // Commit an accepted grant, else release on the last beat
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_busy[m]  <= 1'b0;
        out_in[m]    <= '0;
        grant_ptr[m] <= '0;
      end else if (out_take[m]) begin
        out_busy[m]  <= 1'b1;
        out_in[m]    <= g_idx[m];
        grant_ptr[m] <= PTR_WIDTH'(
          wrap_inc(int'(g_idx[m]), RADIX));
      end else if (xfer_last[m]) begin
        out_busy[m]  <= 1'b0;
      end
    end
  end

  for (genvar n = 0; n < RADIX; n++) begin : g_in
    switch_rr_arbiter #(.RADIX(RADIX)) u_accept (
      .req (a_req[n]),
      .ptr (accept_ptr[n]),
      .gnt (a_gnt[n]),
      .idx (a_idx[n])
    );

    assign a_any[n]  = |a_gnt[n];
    assign rel_in[n] = |r_mat[n];

    // Input side of commit/release; busy inputs never accept
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_busy[n]    <= 1'b0;
        accept_ptr[n] <= '0;
      end else if (a_any[n]) begin
        in_busy[n]    <= 1'b1;
        accept_ptr[n] <= PTR_WIDTH'(
          wrap_inc(int'(a_idx[n]), RADIX));
      end else if (rel_in[n]) begin
        in_busy[n]    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_voq_islip_sched.sv
// Randomized and directed bench for the iSLIP scheduler.
// Reference model tracks connections and pointers as integers.
module tb_switch_voq_islip_sched;

  localparam int R  = 4;
  localparam int NN = R * R;
  localparam int STARVE_BOUND = 200;

  typedef logic [NN-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  vec_t          voq_req;
  logic [R-1:0]  xfer_last;
  vec_t          match;
  logic [R-1:0]  match_valid;

  int checks   = 0;
  int failures = 0;

  int conn [R];
  int gp   [R];
  int ap   [R];
  int rem  [R];
  int wait_c [NN];
  int max_wait;
  bit track;

  always #5 clk = ~clk;

  switch_voq_islip_sched #(.RADIX(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .voq_req     (voq_req),
    .xfer_last   (xfer_last),
    .match       (match),
    .match_valid (match_valid)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit vbit(input vec_t v, input int i);
    return ((v >> i) & vec_t'(1)) != '0;
  endfunction

  function automatic bit lbit(input logic [R-1:0] v, input int i);
    return ((v >> i) & R'(1)) != '0;
  endfunction

  function automatic vec_t exp_match();
    vec_t v = '0;
    for (int m = 0; m < R; m++)
      if (conn[m] >= 0) v |= vec_t'(1) << (m * R + conn[m]);
    return v;
  endfunction

  function automatic logic [R-1:0] exp_valid();
    logic [R-1:0] v = '0;
    for (int m = 0; m < R; m++)
      if (conn[m] >= 0) v |= R'(1) << m;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < R; i++) begin
      conn[i] = -1; gp[i] = 0; ap[i] = 0; rem[i] = 0;
    end
    for (int i = 0; i < NN; i++) wait_c[i] = 0;
    max_wait = 0;
  endtask

  // One scheduling round from the pre-edge state
  task automatic model_step(input vec_t req, input logic [R-1:0] xl);
    int gnt [R];
    int acc [R];
    bit ib  [R];
    for (int n = 0; n < R; n++) ib[n] = 0;
    for (int m = 0; m < R; m++) if (conn[m] >= 0) ib[conn[m]] = 1;
    for (int m = 0; m < R; m++) begin
      gnt[m] = -1;
      if (conn[m] < 0)
        for (int k = 0; k < R; k++) begin
          int n = (gp[m] + k) % R;
          if (gnt[m] < 0 && !ib[n] && vbit(req, n * R + m)) gnt[m] = n;
        end
    end
    for (int n = 0; n < R; n++) begin
      acc[n] = -1;
      if (!ib[n])
        for (int k = 0; k < R; k++) begin
          int m = (ap[n] + k) % R;
          if (acc[n] < 0 && gnt[m] == n) acc[n] = m;
        end
    end
    for (int m = 0; m < R; m++)
      if (conn[m] >= 0 && lbit(xl, m)) conn[m] = -1;
    for (int n = 0; n < R; n++)
      if (acc[n] >= 0) begin
        conn[acc[n]] = n;
        gp[acc[n]]   = (n + 1) % R;
        ap[n]        = (acc[n] + 1) % R;
      end
  endtask

  task automatic check_invariant();
    bit ok = 1;
    for (int a = 0; a < R; a++) begin
      int col = 0;
      int row = 0;
      for (int b = 0; b < R; b++) begin
        col += int'(vbit(match, a * R + b));
        row += int'(vbit(match, b * R + a));
      end
      if (col > 1 || row > 1) ok = 0;
    end
    check("onehot", 64'(ok), 64'h1);
  endtask

  // Drive one cycle at negedge, check at the following negedge
  task automatic step(input vec_t req, input logic [R-1:0] xl);
    voq_req   = req;
    xfer_last = xl;
    model_step(req, xl);
    @(negedge clk);
    check("model_match", 64'(match), 64'(exp_match()));
    check("model_valid", 64'(match_valid), 64'(exp_valid()));
    check_invariant();
    if (track)
      for (int n = 0; n < R; n++)
        for (int m = 0; m < R; m++) begin
          int i = n * R + m;
          if (vbit(req, i) && conn[m] != n) wait_c[i]++;
          else wait_c[i] = 0;
          if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    voq_req   = '0;
    xfer_last = '0;
    model_reset();
    #1;
    check("rst_match", 64'(match), 64'h0);
    check("rst_valid", 64'(match_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Crossbar stand-in: frames of 1..4 beats on connected outputs
  task automatic gen_last(input bit spurious, output logic [R-1:0] xl);
    xl = '0;
    for (int m = 0; m < R; m++) begin
      if (conn[m] >= 0) begin
        if (rem[m] == 0) rem[m] = int'($urandom_range(1, 4));
        if (rem[m] == 1) xl |= R'(1) << m;
        rem[m]--;
      end else if (spurious && $urandom_range(0, 15) == 0) begin
        xl |= R'(1) << m;
      end
    end
  endtask

  initial begin
    vec_t cur;
    logic [R-1:0] xl;
    track = 0;

    do_reset();
    step(16'h0001, 4'b0000);
    check("first_match", 64'(match), 64'h1);
    do_reset();
    step(16'h0001, 4'b0000);
    check("post_rst", 64'(match), 64'h1);
    step(16'h0000, 4'b0001);
    check("release", 64'(match), 64'h0);

    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(16'h1111, 4'b0000);
      check("contend", 64'(match), 64'h1 << (k % 4));
      check("contend_v", 64'(match_valid), 64'h1);
      step(16'h1111, 4'b0001);
      check("contend_gap", 64'(match), 64'h0);
    end

    do_reset();
    step(16'h0A00, 4'b0000);
    check("in_contend_a", 64'(match), 64'h0040);
    step(16'h0A00, 4'b0010);
    check("in_contend_rel", 64'(match), 64'h0);
    step(16'h0A00, 4'b0000);
    check("in_contend_b", 64'(match), 64'h4000);

    do_reset();
    step(16'h8421, 4'b0000);
    check("perm", 64'(match), 64'h8421);
    check("perm_v", 64'(match_valid), 64'hF);
    step(16'h8421, 4'b0101);
    check("perm_rel", 64'(match), 64'h8020);
    check("perm_rel_v", 64'(match_valid), 64'hA);
    step(16'h0000, 4'b0000);
    check("perm_hold", 64'(match), 64'h8020);

    do_reset();
    step(16'h0040, 4'b0000);
    check("hold_a", 64'(match), 64'h0200);
    step(16'h0000, 4'b0000);
    check("hold_b", 64'(match), 64'h0200);
    step(16'h0000, 4'b0001);
    check("idle_last", 64'(match), 64'h0200);
    step(16'h0000, 4'b0100);
    check("hold_rel", 64'(match), 64'h0);
    step(16'h0000, 4'b0100);
    check("idle_last2", 64'(match), 64'h0);
    step(16'h4004, 4'b0000);
    check("ptr_kept", 64'(match), 64'h0800);

    do_reset();
    cur = '0;
    for (int c = 0; c < 600; c++) begin
      cur ^= vec_t'($urandom & $urandom & $urandom);
      gen_last(1'b1, xl);
      step(cur, xl);
    end

    do_reset();
    track = 1;
    for (int c = 0; c < 600; c++) begin
      gen_last(1'b0, xl);
      step('1, xl);
    end
    check("starve", 64'(max_wait <= STARVE_BOUND), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
